// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle control unit.
// States, instruction classes, opcodes and immediate selects.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILL
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  function automatic logic [1:0] imm_of(cls_e c);
    logic [1:0] r;
    r = IMM_I;
    if (c == CLS_STORE) r = IMM_S;
    if (c == CLS_BRANCH) r = IMM_B;
    return r;
  endfunction

  function automatic logic alu_imm(cls_e c);
    return (c == CLS_IALU) || (c == CLS_LOAD) ||
           (c == CLS_STORE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational opcode classifier for the multicycle controller.
// Unknown opcodes map to CLS_ILL with illegal raised.
module multicycle_ctrl_opcode_class
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] cls,
  output logic       illegal
);

  cls_e c;

  always_comb begin
    c = CLS_ILL;
    unique case (1'b1)
      (op == OP_R):      c = CLS_R;
      (op == OP_IALU):   c = CLS_IALU;
      (op == OP_LOAD):   c = CLS_LOAD;
      (op == OP_STORE):  c = CLS_STORE;
      (op == OP_BRANCH): c = CLS_BRANCH;
      default:           c = CLS_ILL;
    endcase
  end

  assign cls     = c;
  assign illegal = (c == CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB.
// Drives datapath strobes and counts retired instructions.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       imm_sel,
  output logic             alu_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [1:0]       imm_sel_q, imm_sel_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [2:0]       dec_cls_raw;
  cls_e             dec_cls;
  logic             dec_ill;
  logic             retire;
  logic             unused_instr;

  assign unused_instr = ^instr[31:7];

  multicycle_ctrl_opcode_class u_cls (
    .op      (opcode_q),
    .cls     (dec_cls_raw),
    .illegal (dec_ill)
  );

  assign dec_cls = cls_e'(dec_cls_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_R;
      opcode_q  <= '0;
      imm_sel_q <= IMM_I;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      opcode_q  <= opcode_d;
      imm_sel_q <= imm_sel_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    opcode_d  = opcode_q;
    imm_sel_d = imm_sel_q;
    retire    = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          opcode_d = instr[6:0];
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cls_d = dec_cls;
        if (dec_ill) begin
          state_d = ST_FETCH;
        end else begin
          imm_sel_d = imm_of(dec_cls);
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls_q == CLS_BRANCH) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (cls_q == CLS_LOAD ||
                     cls_q == CLS_STORE) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (cls_q == CLS_STORE) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    instret_d = retire ? instret_q + ONE : instret_q;
  end

  // Outputs are forced low while reset is held, not just after the edge.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ack;
          pc_write = imem_ack;
        end
        ST_DECODE: illegal = dec_ill;
        ST_EXEC: begin
          alu_src = alu_imm(cls_q);
          if (cls_q == CLS_BRANCH) begin
            pc_write = br_taken;
            pc_src   = 1'b1;
          end
        end
        ST_MEM: begin
          alu_src  = alu_imm(cls_q);
          dmem_req = 1'b1;
          dmem_we  = (cls_q == CLS_STORE);
        end
        ST_WB: begin
          alu_src    = alu_imm(cls_q);
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == CLS_LOAD);
        end
        default: ;
      endcase
    end
  end

  assign imm_sel = imm_sel_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed prologue, then
// random instruction stream with random ack delays and ack noise.
module tb_multicycle_ctrl;

  localparam int CW = 4;
  localparam int N  = 160;

  logic          clk;
  logic          rst_n;
  logic [31:0]   instr;
  logic          imem_ack, dmem_ack, br_taken;
  logic          imem_req, dmem_req, dmem_we;
  logic          ir_write, pc_write, pc_src;
  logic [1:0]    imm_sel;
  logic          alu_src, reg_write, mem_to_reg, illegal;
  logic [CW-1:0] instret;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .br_taken   (br_taken),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .imm_sel    (imm_sel),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] instr;
    int          iw;
    int          dw;
    logic        br;
    logic        rst;
  } item_t;

  // kind: 0 ALU writeback, 1 load, 2 store, 3 branch, 4 illegal
  typedef struct {
    int         kind;
    logic [1:0] imm;
    logic       alu;
    logic       m2r;
    logic       pcw;
    int         lat;
    int         dreq;
    logic       ret;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t model(item_t it, int t0);
    exp_t e;
    e.kind = 4; e.imm = 2'b00; e.alu = 1'b0;
    e.m2r = 1'b0; e.pcw = 1'b0; e.lat = 1;
    e.dreq = 0; e.ret = 1'b1; e.t0 = t0;
    case (it.instr[6:0])
      7'h33: begin e.kind = 0; e.lat = 3; end
      7'h13: begin e.kind = 0; e.alu = 1'b1; e.lat = 3; end
      7'h03: begin
        e.kind = 1; e.alu = 1'b1; e.m2r = 1'b1;
        e.lat = 4 + it.dw; e.dreq = it.dw + 1;
      end
      7'h23: begin
        e.kind = 2; e.imm = 2'b01; e.alu = 1'b1;
        e.lat = 3 + it.dw; e.dreq = it.dw + 1;
      end
      7'h63: begin
        e.kind = 3; e.imm = 2'b10; e.pcw = it.br; e.lat = 2;
      end
      default: e.ret = 1'b0;
    endcase
    return e;
  endfunction

  function automatic item_t make_item(int k);
    item_t it;
    logic [31:0] w;
    logic [6:0] op;
    int r;
    it.iw = 0; it.dw = 0; it.br = 1'b0; it.rst = 1'b0;
    it.instr = 32'h002081B3;
    if (k == 0) it.instr = 32'h00500093;
    else if (k == 1) begin it.instr = 32'h00112223; it.dw = 3; end
    else if (k == 2) begin it.instr = 32'h00208463; it.br = 1'b1; end
    else if (k == 3) it.instr = 32'h00208463;
    else if (k == 4) it.instr = 32'h0000007F;
    else if (k == 5) begin
      it.instr = 32'h00012083; it.dw = 3; it.rst = 1'b1;
    end else if (k >= 22) begin
      r = $urandom_range(0, 5);
      case (r)
        0: op = 7'h33;
        1: op = 7'h13;
        2: op = 7'h03;
        3: op = 7'h23;
        4: op = 7'h63;
        default: begin
          do op = 7'($urandom_range(0, 127));
          while (op == 7'h33 || op == 7'h13 || op == 7'h03 ||
                 op == 7'h23 || op == 7'h63);
        end
      endcase
      w = $urandom;
      it.instr = {w[31:7], op};
      it.iw = $urandom_range(0, 2);
      it.dw = $urandom_range(0, 3);
      it.br = 1'($urandom_range(0, 1));
    end
    return it;
  endfunction

  // Driver: answers handshakes, injects ack noise outside the handshakes.
  initial begin
    item_t cur, fl;
    int fcnt, dcnt, issued;
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    br_taken = 1'b0; instr = '0;
    issued = 0; fcnt = 0; dcnt = 0;
    cur = make_item(0); fl = cur;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      if (issued == N && sb.size() == 0) break;
      @(negedge clk);
      if (imem_req) begin
        if (issued < N && fcnt >= cur.iw) begin
          imem_ack = 1'b1; instr = cur.instr; br_taken = cur.br;
          sb.push_back(model(cur, cyc));
          fl = cur; issued++; fcnt = 0; dcnt = 0;
          cur = make_item(issued);
        end else begin
          imem_ack = 1'b0; instr = $urandom; fcnt++;
        end
      end else begin
        imem_ack = 1'($urandom_range(0, 1)); instr = $urandom;
      end
      if (dmem_req) begin
        if (fl.rst && dcnt == 1) begin
          rst_n = 1'b0; dmem_ack = 1'b0; imem_ack = 1'b0;
          repeat (2) @(negedge clk);
          rst_n = 1'b1; dcnt = 0; fcnt = 0; fl.rst = 1'b0;
        end else begin
          dmem_ack = (dcnt == fl.dw); dcnt++;
        end
      end else begin
        dmem_ack = 1'($urandom_range(0, 1));
      end
    end
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (issued != N || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: issued %0d of %0d, %0d pending",
               issued, N, sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  // Monitor: pops an expectation at each instruction-ending strobe.
  initial begin
    exp_t e;
    int kind, dreq_cnt;
    bit chk_ir, prev_rst;
    logic [CW-1:0] exp_ir;
    logic st_end;
    dreq_cnt = 0; chk_ir = 1'b0; prev_rst = 1'b0; exp_ir = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        checks++;
        if ({imem_req, dmem_req, dmem_we, ir_write, pc_write,
             pc_src, alu_src, reg_write, mem_to_reg, illegal,
             imm_sel} !== 12'h000) begin
          errors++;
          $display("FAIL reset_outs: got req=%b dreq=%b we=%b imm=%b",
                   imem_req, dmem_req, dmem_we, imm_sel);
        end
        checks++;
        if (instret !== '0) begin
          errors++;
          $display("FAIL reset_instret: got %0d want 0", instret);
        end
        sb.delete(); exp_ir = '0; chk_ir = 1'b0;
        dreq_cnt = 0; prev_rst = 1'b1;
        continue;
      end
      if (prev_rst) begin
        checks++;
        if (imem_req !== 1'b1) begin
          errors++;
          $display("FAIL post_reset_req: got %b want 1", imem_req);
        end
        prev_rst = 1'b0;
      end
      if (chk_ir) begin
        checks++;
        if (instret !== exp_ir) begin
          errors++;
          $display("FAIL instret: got %0d want %0d", instret, exp_ir);
        end
        chk_ir = 1'b0;
      end
      if (dmem_req) dreq_cnt++;
      if (ir_write) begin
        checks++;
        if (!(pc_write === 1'b1 && pc_src === 1'b0 &&
              imem_ack === 1'b1)) begin
          errors++;
          $display("FAIL fetch_strobe: pcw=%b pcsrc=%b ack=%b want 1 0 1",
                   pc_write, pc_src, imem_ack);
        end
      end
      st_end = dmem_req & dmem_we & dmem_ack;
      if (reg_write | pc_src | illegal | st_end) begin
        kind = illegal ? 4 : pc_src ? 3 : st_end ? 2 :
               mem_to_reg ? 1 : 0;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_end: got kind %0d want none", kind);
        end else begin
          e = sb.pop_front();
          checks++;
          if (kind != e.kind) begin
            errors++;
            $display("FAIL kind: got %0d want %0d", kind, e.kind);
          end
          checks++;
          if (cyc - e.t0 != e.lat) begin
            errors++;
            $display("FAIL latency: got %0d want %0d",
                     cyc - e.t0, e.lat);
          end
          checks++;
          if (dreq_cnt != e.dreq) begin
            errors++;
            $display("FAIL dmem_req_cycles: got %0d want %0d",
                     dreq_cnt, e.dreq);
          end
          checks++;
          if (alu_src !== e.alu || mem_to_reg !== e.m2r) begin
            errors++;
            $display("FAIL alu_m2r: got %b%b want %b%b",
                     alu_src, mem_to_reg, e.alu, e.m2r);
          end
          if (e.kind != 4) begin
            checks++;
            if (imm_sel !== e.imm) begin
              errors++;
              $display("FAIL imm_sel: got %b want %b", imm_sel, e.imm);
            end
          end
          if (e.kind == 3) begin
            checks++;
            if (pc_write !== e.pcw) begin
              errors++;
              $display("FAIL branch_pcw: got %b want %b",
                       pc_write, e.pcw);
            end
          end
          if (e.ret) exp_ir = exp_ir + 1'b1;
          chk_ir = 1'b1;
        end
        dreq_cnt = 0;
      end
    end
  end

endmodule
